vfu_result_collector: RTL and testbench
=======================================

VFU_RESULT_COLLECTOR -- requirements
Module: vfu_result_collector

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of lanes (FP units).
REQ-002 SHALL have parameter WIDTH, default 16, meaning bits per lane result (FP16).
REQ-003 SHALL have parameter DEPTH, default 4, meaning per-lane buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of all buffered results.
REQ-007 SHALL have port lane_tvalid  input  N  per-lane m_axis_result_tvalid from the FP units.
REQ-008 SHALL have port lane_tdata  input  N*WIDTH  per-lane m_axis_result_tdata; lane i at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port lane_tready  output  N  per-lane m_axis_result_tready to the FP units.
REQ-010 SHALL have port out_valid  output  1  a full N-lane result vector is presented.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the vector.
REQ-012 SHALL have port out_vec  output  N*WIDTH  aligned result vector; lane i at [i*WIDTH +: WIDTH].
REQ-013 SHALL have port out_level  output  $clog2(DEPTH+1)  number of complete vectors buffered (minimum lane count).
REQ-014 SHALL have port skew_err  output  1  sticky flag: lane counts differed by DEPTH (one lane full, another empty).

Function
REQ-015 Each lane SHALL own an independent FIFO of DEPTH entries with a count register 0..DEPTH.
REQ-016 lane_tready[i] SHALL be 1 exactly when lane i count < DEPTH, decoded from registered count only (no combinational path from out_ready).
REQ-017 Lane i SHALL push when lane_tvalid[i] && lane_tready[i]; data with tvalid and tready low SHALL be held by the source, not dropped.
REQ-018 out_valid SHALL be 1 exactly when every lane count >= 1.
REQ-019 out_vec SHALL present the head entry of every lane; its value is don't-care when out_valid=0.
REQ-020 A pop SHALL occur when out_valid && out_ready, removing the head of all N lanes in the same cycle.
REQ-021 Latency: a result pushed in cycle t SHALL be visible at out_vec in cycle t+1 at the earliest (no fall-through).
REQ-022 Simultaneous push and pop on one lane SHALL leave its count unchanged; a full lane SHALL NOT accept a push in the cycle it pops (tready already 0).
REQ-023 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 out_valid/out_vec SHALL hold stable while out_valid && !out_ready.
REQ-025 out_level SHALL equal the minimum of the N lane counts, updated one cycle after push/pop.
REQ-026 skew_err SHALL set when any lane count = DEPTH while another lane count = 0, and clear only on rst or flush.
REQ-027 flush SHALL zero all counts and pointers and clear skew_err next cycle; a push or pop coincident with flush SHALL be discarded.

Reset
REQ-028 rst SHALL asynchronously force all counts, pointers and skew_err to 0, giving lane_tready=all ones, out_valid=0, out_level=0.
REQ-029 Buffer storage SHALL NOT be reset; rst mid-transfer SHALL drop all buffered results with no partial vector emitted after release.

Structure
REQ-030 N, WIDTH and DEPTH defaults and the lane slicing convention SHALL live in the shared VFU package/header used by addsub and other VFU blocks.
REQ-031 One sub-module vfu_lane_fifo (WIDTH, DEPTH; push, pop, flush, data, count, full, empty) SHALL be instantiated N times via generate.

Verification
REQ-032 All lanes tvalid with 0x3C00,0x4000,0x4200,0x4400 in cycle 1, out_ready=1 -> out_valid=1 in cycle 2 with that vector, popped, out_level back to 0.
REQ-033 Lane 0 valid cycles 1-3, lanes 1-3 valid cycles 3-5 (skewed) -> out_valid first rises in cycle 4; three vectors emitted in push order, none mixed.
REQ-034 out_ready=0, all lanes valid 6 cycles (DEPTH=4) -> lane_tready=0 after 4 pushes, out_level=4; raise out_ready -> 4 vectors drained in order, tready returns 1 after first pop.
REQ-035 Only lane 2 valid 4 cycles, others idle -> lane_tready[2]=0, skew_err=1, out_valid=0; flush -> skew_err=0, all counts 0.
REQ-036 rst asserted mid-burst with 2 vectors buffered -> out_valid=0 and lane_tready=all ones immediately (asynchronously), no stale vector after release.
REQ-037 Full lane with simultaneous pop and tvalid -> count 3 next cycle, the offered datum is accepted only in the following cycle.

Source files
------------

// File: rtl/vfu_result_collector_pkg.sv
// vfu_result_collector_pkg: shared VFU lane-count/width/depth defaults and lane slicing helper
package vfu_result_collector_pkg;
    localparam int VFU_N     = 4;
    localparam int VFU_WIDTH = 16;
    localparam int VFU_DEPTH = 4;

    // Lane i of a packed N*WIDTH bus sits at [i*WIDTH +: WIDTH]
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/vfu_result_collector_if.sv
// vfu_result_collector_if: per-lane FP result streams in, aligned result vector out
interface vfu_result_collector_if
    import vfu_result_collector_pkg::*;
#(
    parameter int N     = VFU_N,
    parameter int WIDTH = VFU_WIDTH
) ();
    logic [N-1:0]       lane_tvalid;
    logic [N*WIDTH-1:0] lane_tdata;
    logic [N-1:0]       lane_tready;
    logic               out_valid;
    logic               out_ready;
    logic [N*WIDTH-1:0] out_vec;

    modport master (
        output lane_tvalid, lane_tdata, out_ready,
        input  lane_tready, out_valid, out_vec
    );

    modport slave (
        input  lane_tvalid, lane_tdata, out_ready,
        output lane_tready, out_valid, out_vec
    );
endinterface

// File: rtl/vfu_result_collector_lane_fifo.sv
// vfu_lane_fifo: one lane's result buffer; registered head, no fall-through, flush wins over push/pop
module vfu_lane_fifo
    import vfu_result_collector_pkg::*;
#(
    parameter int  WIDTH = VFU_WIDTH,
    parameter int  DEPTH = VFU_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Qualify requests against registered full/empty; pointers wrap naturally at DEPTH
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
        count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    // Occupancy state is cleared asynchronously so tready comes back immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; stale entries are unreachable once count is zero
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/vfu_result_collector.sv
// vfu_result_collector: realigns N independently-timed FP lane results into whole vectors
module vfu_result_collector
    import vfu_result_collector_pkg::*;
#(
    parameter int  N     = VFU_N,
    parameter int  WIDTH = VFU_WIDTH,
    parameter int  DEPTH = VFU_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    vfu_result_collector_if.slave bus,
    output logic [CW-1:0]        out_level,
    output logic                 skew_err
);
    logic [N-1:0]  full, empty;
    logic [CW-1:0] cnt [N];
    logic [CW-1:0] level;
    logic          pop;
    logic          skew_q, skew_d;

    assign bus.lane_tready = ~full;
    assign bus.out_valid   = ~|empty;
    assign pop             = bus.out_valid && bus.out_ready;
    assign out_level       = level;
    assign skew_err        = skew_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        vfu_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (bus.lane_tvalid[i] && !full[i]),
            .pop   (pop),
            .din   (bus.lane_tdata[lane_lsb(i, WIDTH) +: WIDTH]),
            .dout  (bus.out_vec[lane_lsb(i, WIDTH) +: WIDTH]),
            .count (cnt[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // Complete vectors = shallowest lane; skew is sticky once one lane fills while another is empty
    always_comb begin
        level = cnt[0];
        for (int i = 1; i < N; i++) level = cnt[i] < level ? cnt[i] : level;
        skew_d = flush ? 1'b0 : skew_q | (|full && |empty);
    end

    // Sticky skew flag, cleared by reset or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) skew_q <= 1'b0;
        else     skew_q <= skew_d;
    end
endmodule

// File: tb/tb_vfu_result_collector.sv
// tb_vfu_result_collector: directed + random stimulus checked against per-lane queue model
module tb_vfu_result_collector;
    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fl  = 1'b0;
    logic [N-1:0]   tv = '0;
    logic [N*W-1:0] td = '0;
    logic           ordy = 1'b0;
    logic [2:0]     out_level;
    logic           skew_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mq [N][$];
    bit           mskew = 0;

    vfu_result_collector_if #(.N(N), .WIDTH(W)) bus ();

    assign bus.lane_tvalid = tv;
    assign bus.lane_tdata  = td;
    assign bus.out_ready   = ordy;

    vfu_result_collector #(.N(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (fl),
        .bus       (bus.slave),
        .out_level (out_level),
        .skew_err  (skew_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] mk(input int k);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i * 16'h1000 + k);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        mskew = 0;
    endtask

    // Called at a falling edge with inputs applied: compare, advance model, move to next falling edge
    task automatic step();
        logic [N-1:0]   erdy;
        logic [N*W-1:0] evec;
        bit             ev, af, ae;
        int             mn;
        ev = 1; af = 0; ae = 0; mn = D; evec = '0;
        for (int i = 0; i < N; i++) begin
            erdy[i] = mq[i].size() < D;
            if (mq[i].size() == 0) begin ev = 0; ae = 1; end
            else evec[i*W +: W] = mq[i][0];
            if (mq[i].size() == D) af = 1;
            if (mq[i].size() < mn) mn = mq[i].size();
        end
        check("tready", 64'(bus.lane_tready), 64'(erdy));
        check("out_valid", 64'(bus.out_valid), 64'(ev));
        if (ev) check("out_vec", 64'(bus.out_vec), 64'(evec));
        check("out_level", 64'(out_level), 64'(mn));
        check("skew_err", 64'(skew_err), 64'(mskew));
        if (fl) model_clear();
        else begin
            mskew = mskew | (af && ae);
            if (ev && ordy) for (int i = 0; i < N; i++) void'(mq[i].pop_front());
            for (int i = 0; i < N; i++) if (tv[i] && erdy[i]) mq[i].push_back(td[i*W +: W]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] skew_tv [5];
        skew_tv = '{4'h1, 4'h1, 4'hF, 4'hE, 4'hE};
        @(negedge clk);
        check("rst_tready", 64'(bus.lane_tready), 64'hF);
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_level", 64'(out_level), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        // single vector, immediate drain
        tv = 4'hF; td = 64'h4400_4200_4000_3C00; ordy = 1'b1;
        step();
        tv = '0;
        check("vec1_valid", 64'(bus.out_valid), 64'h1);
        check("vec1_data", 64'(bus.out_vec), 64'h4400_4200_4000_3C00);
        step();
        check("vec1_level", 64'(out_level), 64'h0);
        // skewed lanes
        for (int k = 0; k < 5; k++) begin
            check("skew_valid_rise", 64'(bus.out_valid), 64'(k >= 3));
            tv = skew_tv[k]; td = mk(16'h0A00 + k);
            step();
        end
        tv = '0;
        for (int k = 0; k < 3; k++) step();
        // backpressure fill then drain
        ordy = 1'b0;
        for (int k = 0; k < 6; k++) begin tv = 4'hF; td = mk(16'h0100 + k); step(); end
        check("bp_tready", 64'(bus.lane_tready), 64'h0);
        check("bp_level", 64'(out_level), 64'h4);
        ordy = 1'b1; tv = '0;
        step();
        check("bp_tready_back", 64'(bus.lane_tready), 64'hF);
        for (int k = 0; k < 4; k++) step();
        // full lane: pop and offer in same cycle
        ordy = 1'b0;
        for (int k = 0; k < 4; k++) begin tv = 4'hF; td = mk(16'h0200 + k); step(); end
        ordy = 1'b1; td = mk(16'h0300);
        step();
        check("full_pop_level", 64'(out_level), 64'h3);
        step();
        check("full_push_level", 64'(out_level), 64'h3);
        tv = '0;
        for (int k = 0; k < 5; k++) step();
        // one lane runs ahead until full
        for (int k = 0; k < 4; k++) begin tv = 4'b0100; td = mk(16'h0400 + k); step(); end
        tv = '0;
        step();
        check("lane2_tready", 64'(bus.lane_tready), 64'hB);
        check("skew_set", 64'(skew_err), 64'h1);
        check("skew_valid", 64'(bus.out_valid), 64'h0);
        fl = 1'b1;
        step();
        fl = 1'b0;
        check("flush_skew", 64'(skew_err), 64'h0);
        check("flush_level", 64'(out_level), 64'h0);
        check("flush_tready", 64'(bus.lane_tready), 64'hF);
        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(tv[i] && mq[i].size() == D)) begin
                    tv[i] = $urandom_range(0, 2) != 0;
                    td[i*W +: W] = W'($urandom);
                end
            end
            ordy = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 40) == 0;
            step();
        end
        fl = 1'b0;
        fl = 1'b1; tv = '0; step(); fl = 1'b0;
        // asynchronous reset with vectors buffered
        ordy = 1'b0; tv = 4'hF;
        td = mk(16'h0500); step();
        td = mk(16'h0501); step();
        check("pre_rst_level", 64'(out_level), 64'h2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'h0);
        check("arst_tready", 64'(bus.lane_tready), 64'hF);
        check("arst_level", 64'(out_level), 64'h0);
        model_clear();
        tv = '0; ordy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
